// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared constants and helpers for the round-robin arbiter family
//            (index-width derivation, one-hot-or-zero check, defaults).
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int DEF_REQ_NUM = 8;
  localparam int DEF_DATA_W  = 8;
  // Widest request vector the helper functions accept.
  localparam int MAX_REQ_NUM = 32;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // True when at most one bit of the vector is set.
  function automatic logic onehot0(input logic [MAX_REQ_NUM-1:0] vec);
    return ((vec & (vec - MAX_REQ_NUM'(1))) == '0);
  endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_req_slot.sv
`default_nettype none
// ============================================================================
// Module   : arb_req_slot
// Purpose  : One producer port of the requester agent: single-word hold
//            register, ready generation and saturating wait counter.
// Revision : 1.0 - initial release
// ============================================================================
module arb_req_slot
  import arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pop,
  output logic              in_ready,
  output logic              hold_valid,
  output logic [DATA_W-1:0] hold_data,
  output logic              starved
);

  localparam int                WAIT_W   = clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM);

  logic [WAIT_W-1:0] wait_cnt;
  logic              take;

  // A popped slot can be refilled in the same cycle, so ready includes pop.
  assign in_ready = !hold_valid || pop;
  assign take     = in_valid && in_ready;
  assign starved  = (wait_cnt == WAIT_MAX);

  // Hold register: load on handshake (also covers pop+refill), empty on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (take) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  // Wait counter: counts held cycles (backpressure included), saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!hold_valid || pop) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule : arb_req_slot
`default_nettype wire

// File: rtl/arb_req_agent.sv
`default_nettype none
// ============================================================================
// Module   : arb_req_agent
// Purpose  : Requester-side agent for the round-robin arbiter. Buffers one
//            word per port, raises reqs, checks grant legality, forwards the
//            granted word to a registered output stage with its port index,
//            and reports protocol errors and per-port starvation.
// Revision : 1.0 - initial release
// ============================================================================
module arb_req_agent
  import arb_pkg::*;
#(
  parameter  int REQ_NUM    = DEF_REQ_NUM,  // 2..MAX_REQ_NUM
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int STARVE_LIM = 16,
  localparam int IDX_W      = clog2(REQ_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REQ_NUM-1:0]        in_valid,
  output logic [REQ_NUM-1:0]        in_ready,
  input  logic [REQ_NUM*DATA_W-1:0] in_data,
  output logic [REQ_NUM-1:0]        reqs,
  input  logic [REQ_NUM-1:0]        grants,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      proto_err,
  output logic [REQ_NUM-1:0]        starved
);

  logic [REQ_NUM-1:0] hold_valid;
  logic [DATA_W-1:0]  hold_data [REQ_NUM];
  logic [REQ_NUM-1:0] pop;
  logic               can_take;
  logic               legal;
  logic [IDX_W-1:0]   pop_idx;
  logic [DATA_W-1:0]  pop_data;

  // reqs never looks at grants, so the arbiter sees no combinational loop.
  assign can_take = !out_valid || out_ready;
  assign reqs     = hold_valid & {REQ_NUM{can_take}};

  // A grant subset of reqs already implies can_take, so a legal pop always
  // has room in the output stage.
  assign legal = onehot0(MAX_REQ_NUM'(grants)) && ((grants & ~reqs) == '0);
  assign pop   = legal ? grants : '0;

  generate
    for (genvar i = 0; i < REQ_NUM; i++) begin : g_slot
      arb_req_slot #(
        .DATA_W     (DATA_W),
        .STARVE_LIM (STARVE_LIM)
      ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[i]),
        .in_data    (in_data[i*DATA_W +: DATA_W]),
        .pop        (pop[i]),
        .in_ready   (in_ready[i]),
        .hold_valid (hold_valid[i]),
        .hold_data  (hold_data[i]),
        .starved    (starved[i])
      );
    end
  endgenerate

  // Encode the (at most one-hot) pop vector into an index and select its word.
  always_comb begin
    pop_idx  = '0;
    pop_data = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (pop[i]) begin
        pop_idx = i[IDX_W-1:0];
      end
      pop_data = pop_data | (hold_data[i] & {DATA_W{pop[i]}});
    end
  end

  // Output stage: load on pop, drain on consumption, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (pop != '0) begin
      out_valid <= 1'b1;
      out_data  <= pop_data;
      out_idx   <= pop_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if (!legal) begin
      proto_err <= 1'b1;
    end
  end

endmodule : arb_req_agent
`default_nettype wire

// File: tb/tb_arb_req_agent.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_req_agent
// Purpose  : Self-checking bench for arb_req_agent with a behavioural model
//            and a round-robin grant generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_req_agent;

  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int LIM = 4;
  localparam int IW  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    reqs;
  logic [N-1:0]    grants = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            proto_err;
  logic [N-1:0]    starved;

  always #5 clk = ~clk;

  arb_req_agent #(
    .REQ_NUM    (N),
    .DATA_W     (DW),
    .STARVE_LIM (LIM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .reqs      (reqs),
    .grants    (grants),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .proto_err (proto_err),
    .starved   (starved)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Behavioural model state
  logic [N-1:0]  m_hv;
  logic [DW-1:0] m_hd [N];
  int            m_wt [N];
  logic          m_ov;
  logic [DW-1:0] m_od;
  int            m_oi;
  logic          m_perr;
  int            rr_ptr;
  logic [N-1:0]  last_in_ready;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hv   = '0;
    m_ov   = 1'b0;
    m_od   = '0;
    m_oi   = 0;
    m_perr = 1'b0;
    rr_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_hd[i] = '0;
      m_wt[i] = 0;
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'($urandom);
  endtask

  // One clock cycle. Entered just after a falling edge with inputs set.
  // mode 0: no grant, 1: round-robin grant, 2: forced grant vector fg.
  task automatic step(input int mode, input logic [N-1:0] fg);
    logic         can_take;
    logic [N-1:0] m_reqs, m_pop, m_inr, m_st, g;
    logic         legal;
    int           gi;
    can_take = !m_ov || out_ready;
    m_reqs   = can_take ? m_hv : '0;
    g = '0;
    if (mode == 1) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (rr_ptr + k) % N;
        if (m_reqs[p] && (g == '0)) begin
          g[p]   = 1'b1;
          rr_ptr = (p + 1) % N;
        end
      end
    end else if (mode == 2) begin
      g = fg;
    end
    grants = g;
    legal  = ($countones(g) <= 1) && ((g & ~m_reqs) == '0);
    m_pop  = legal ? g : '0;
    m_inr  = ~m_hv | m_pop;
    for (int i = 0; i < N; i++) m_st[i] = (m_wt[i] == LIM);
    #1;
    last_in_ready = in_ready;
    cmp("in_ready", 64'(in_ready), 64'(m_inr));
    cmp("reqs", 64'(reqs), 64'(m_reqs));
    cmp("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      cmp("out_data", 64'(out_data), 64'(m_od));
      cmp("out_idx", 64'(out_idx), 64'(m_oi));
    end
    cmp("proto_err", 64'(proto_err), 64'(m_perr));
    cmp("starved", 64'(starved), 64'(m_st));
    // Advance the model across the rising edge.
    gi = -1;
    for (int i = 0; i < N; i++) if (m_pop[i]) gi = i;
    if (gi >= 0) begin
      m_ov = 1'b1;
      m_od = m_hd[gi];
      m_oi = gi;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!m_hv[i] || m_pop[i]) m_wt[i] = 0;
      else if (m_wt[i] < LIM)   m_wt[i] = m_wt[i] + 1;
      if (in_valid[i] && m_inr[i]) begin
        m_hv[i] = 1'b1;
        m_hd[i] = in_data[i*DW +: DW];
      end else if (m_pop[i]) begin
        m_hv[i] = 1'b0;
      end
    end
    if (!legal) m_perr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #2;
    rst_n    = 1'b0;
    in_valid = '0;
    grants   = '0;
    #1;
    cmp("rst out_valid", 64'(out_valid), 64'd0);
    cmp("rst reqs", 64'(reqs), 64'd0);
    cmp("rst proto_err", 64'(proto_err), 64'd0);
    cmp("rst starved", 64'(starved), 64'd0);
    cmp("rst out_data", 64'(out_data), 64'd0);
    cmp("rst out_idx", 64'(out_idx), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single word on port 3
    out_ready = 1'b1;
    in_valid  = 8'h08;
    in_data   = '0;
    in_data[3*DW +: DW] = 8'hA5;
    step(1, '0);
    in_valid = '0;
    cmp("B reqs", 64'(reqs), 64'h08);
    step(1, '0);
    cmp("B out_valid", 64'(out_valid), 64'd1);
    cmp("B out_data", 64'(out_data), 64'hA5);
    cmp("B out_idx", 64'(out_idx), 64'd3);
    cmp("B proto_err", 64'(proto_err), 64'd0);

    // Pop and refill of port 0 in the same cycle
    in_valid = 8'h01;
    in_data[DW-1:0] = 8'h11;
    step(0, '0);
    in_data[DW-1:0] = 8'h22;
    step(2, 8'h01);
    cmp("refill in_ready0", 64'(last_in_ready[0]), 64'd1);
    in_valid = '0;
    cmp("refill reqs0", 64'(reqs[0]), 64'd1);
    cmp("refill first data", 64'(out_data), 64'h11);
    step(2, 8'h01);
    cmp("refill second data", 64'(out_data), 64'h22);
    cmp("refill second idx", 64'(out_idx), 64'd0);
    cmp("refill second valid", 64'(out_valid), 64'd1);

    // All ports streaming through a round-robin arbiter
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k >= 2) begin
        cmp("rr out_valid", 64'(out_valid), 64'd1);
        cmp("rr out_idx", 64'(out_idx), 64'((k - 2) % N));
      end
      in_valid = '1;
      rand_data();
      step(1, '0);
    end

    // Backpressure: everything held, waits saturate
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      step(1, '0);
    end
    cmp("stall reqs", 64'(reqs), 64'd0);
    cmp("stall starved", 64'(starved), 64'hFF);
    cmp("stall out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rand_data();
      step(1, '0);
    end

    // Random traffic with legal grants only
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_valid  = N'($urandom);
      rand_data();
      out_ready = ($urandom_range(9) < 7);
      step(($urandom_range(9) < 8) ? 1 : 0, '0);
    end

    // Multi-bit grant
    do_reset();
    out_ready = 1'b1;
    in_valid  = 8'h05;
    rand_data();
    step(0, '0);
    in_valid = '0;
    cmp("ill reqs", 64'(reqs), 64'h05);
    step(2, 8'h05);
    cmp("ill proto_err", 64'(proto_err), 64'd1);
    cmp("ill out_valid", 64'(out_valid), 64'd0);
    cmp("ill no pop", 64'(reqs), 64'h05);
    for (int k = 0; k < 4; k++) step(1, '0);
    cmp("ill sticky", 64'(proto_err), 64'd1);

    // Grant to a non-requesting port
    do_reset();
    in_valid = 8'h01;
    step(0, '0);
    in_valid = '0;
    step(2, 8'h02);
    cmp("ill2 proto_err", 64'(proto_err), 64'd1);
    cmp("ill2 out_valid", 64'(out_valid), 64'd0);

    // Reset with held words and a valid output
    do_reset();
    out_ready = 1'b0;
    in_valid  = 8'h1F;
    rand_data();
    step(0, '0);
    in_valid = '0;
    step(2, 8'h10);
    cmp("mid out_valid", 64'(out_valid), 64'd1);
    cmp("mid out_idx", 64'(out_idx), 64'd4);
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step(1, '0);
    cmp("post rst out_valid", 64'(out_valid), 64'd0);
    cmp("post rst reqs", 64'(reqs), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_arb_req_agent
`default_nettype wire

// File: doc/arb_req_agent.md
Name: arb_req_agent

Overview:
- Requester-side agent for the round-robin arbiter; sits between N producer ports and the arbiter's reqs/grants interface.
- Buffers one word per port and drives the port's req bit while that word is held.
- On a legal grant it moves the granted word into a registered output stage, tagged with its port index.
- Checks the arbiter protocol and measures per-port wait time for starvation detection.

Parameters:
REQ_NUM, 8, number of requester ports (≥2)
DATA_W, 8, payload width per port
STARVE_LIM, 16, wait cycles after which a pending port is flagged starved (≥1)

Ports:
clk  input  1  clock
rst_n  input  1  reset
in_valid  input  REQ_NUM  per-port producer valid
in_ready  output  REQ_NUM  per-port producer ready
in_data  input  REQ_NUM*DATA_W  port i payload at [i*DATA_W +: DATA_W]
reqs  output  REQ_NUM  request vector to arbiter
grants  input  REQ_NUM  grant vector from arbiter, one-hot or zero
out_valid  output  1  granted word available
out_ready  input  1  downstream accepts word
out_data  output  DATA_W  granted payload
out_idx  output  IDX_W  granted port index; IDX_W = $clog2(REQ_NUM)
proto_err  output  1  sticky arbiter protocol violation
starved  output  REQ_NUM  per-port wait ≥ STARVE_LIM

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low, rst_n. While rst_n is low: hold_valid, out_valid, proto_err, starved and all wait counters are 0; out_data and out_idx are 0; reqs is 0.
- Hold stage, per port i: hold_valid[i] and hold_data[i].
  - in_ready[i] = !hold_valid[i] | pop[i]. A pop and a refill in the same cycle are legal: the slot stays full with the new data.
  - An input handshake in cycle t makes the word held, and reqs[i] asserted, from t+1.
- can_take = !out_valid | out_ready.
- reqs[i] = hold_valid[i] & can_take. reqs is combinational from registers and out_ready only; it never depends on grants.
- Grant handling: grants are sampled in the same cycle as the reqs they answer.
  - legal = onehot0(grants) and (grants & ~reqs) == 0.
  - If legal and grants[i] is set: pop[i]=1. Next cycle out_valid=1, out_data=hold_data[i], out_idx=i.
  - Output latency from input handshake to out_valid is therefore 2 cycles minimum.
- Illegal grant (multiple bits set, or a bit for a non-requesting port): proto_err is set next cycle and stays set until reset; no pop; the output stage is unchanged.
- Grants arriving while reqs==0 (stall or empty) are illegal if any bit is set.
- Output stage:
  - out_valid clears on out_valid & out_ready unless a new pop loads it in the same cycle; in that case it stays 1 with the new data.
  - out_data and out_idx are stable while out_valid & !out_ready.
- Wait counter per port, saturating at STARVE_LIM:
  - Cleared when hold_valid[i]=0 or pop[i].
  - Otherwise incremented every cycle hold_valid[i]=1. This includes cycles where reqs is masked by backpressure.
  - starved[i] = (wait[i] == STARVE_LIM), registered. It clears the cycle after the pop.
- Reset mid-operation: all held and output words are discarded immediately; nothing is replayed after reset.

Decomposition:
- Shared package arb_pkg: function clog2 / IDX_W derivation, onehot0 check function, default REQ_NUM and DATA_W constants. The arbiter and its bench reuse these.
- Natural sub-module: arb_req_slot. It holds one port's hold register, ready logic and saturating wait counter, and is instantiated REQ_NUM times by generate.
- Top level contains grant legality, the output mux/register and proto_err.

Test Plan:
- Reset release, then port 3 sends 0xA5 with out_ready=1 and the arbiter grants 0x08 when reqs=0x08 -> reqs=0x08 one cycle after the handshake; out_valid=1, out_data=0xA5, out_idx=3 the cycle after the grant; proto_err=0.
- All 8 ports valid continuously, real round_robin_arbiter_base connected, out_ready=1 -> out_idx sequence 0,1,…,7,0 repeating with one word per cycle; no starved bit ever set; proto_err=0.
- out_ready=0 for 5 cycles with out_valid=1 -> reqs=0x00 throughout; out_data/out_idx unchanged; wait counters increment. With STARVE_LIM=4, starved asserts for held ports.
- Forced grants=0x05 while reqs=0x05 -> proto_err=1 next cycle and remains 1; no pop; out_valid unchanged. Same result for grants=0x02 while reqs=0x01.
- Port 0 pop and new in_valid in the same cycle -> in_ready[0]=1; reqs[0] stays 1 without a gap; the second word is output with out_idx=0 on the next grant.
- rst_n pulled low while out_valid=1 and 4 ports held -> all outputs 0 asynchronously; after release, no stale word appears.
